// File: rtl/xge_pkg.sv
// ============================================================================
//  xge_pkg
//  Shared constants for the 10G transmit path: buffer sizing, entry layout
//  and read-side FSM state encodings.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package xge_pkg;

  localparam int unsigned c_bw_default = 10;
  localparam int unsigned c_data_w     = 64;
  localparam int unsigned c_strb_w     = 8;
  localparam int unsigned c_entry_w    = c_data_w + c_strb_w + 1;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_start  = 3'd2;
  localparam logic [2:0] c_st_stream = 3'd3;
  localparam logic [2:0] c_st_gap    = 3'd4;

endpackage

`default_nettype wire

// File: rtl/xge_ibuf.sv
// ============================================================================
//  xge_ibuf
//  Simple dual-port buffer: synchronous write port, registered read port.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module xge_ibuf #(
  parameter int AW = 10,
  parameter int DW = 73
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  input  logic          qdpo_clk,
  input  logic [AW-1:0] dpra,
  output logic [DW-1:0] qdpo
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) r_mem[a] <= d;
  end

  always_ff @(posedge qdpo_clk) begin
    qdpo <= r_mem[dpra];
  end

endmodule

`default_nettype wire

// File: rtl/axis2mac.sv
// ============================================================================
//  axis2mac
//  Store-and-forward bridge from an AXI-Stream frame source to a 64-bit MAC
//  transmit interface, discarding frames larger than the buffer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module axis2mac
  import xge_pkg::*;
#(
  parameter int BW = c_bw_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tstrb,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] mac_tx_data,
  output logic [7:0]  mac_tx_data_valid,
  output logic        mac_tx_start,
  input  logic        mac_tx_ack,
  output logic [15:0] dropped_pkts
);

  localparam logic [BW:0] c_depth = {1'b1, {BW{1'b0}}};

  logic [BW:0]   r_wr;
  logic [BW:0]   r_cwr;
  logic [BW:0]   r_rd;
  logic          r_drop;
  logic [15:0]   r_dropped;
  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_start_seen;

  logic          w_full;
  logic          w_drop_start;
  logic          w_beat;
  logic          w_wr_en;
  logic          w_avail;
  logic          w_consume;
  logic [BW-1:0] w_rd_addr;
  logic [72:0]   w_wr_word;
  logic [72:0]   w_rd_word;
  logic          w_rd_last;

  assign w_full = (r_wr - r_rd) == c_depth;

  // The whole buffer is held by one unfinished frame: it can never commit,
  // so rewind it and swallow the remainder.
  assign w_drop_start = w_full && (r_cwr == r_rd) && !r_drop;

  assign s_axis_tready = !rst && (!w_full || r_drop || w_drop_start);
  assign w_beat        = s_axis_tvalid && s_axis_tready;
  assign w_wr_en       = w_beat && !r_drop && !w_drop_start;
  assign w_wr_word     = {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
  assign dropped_pkts  = r_dropped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr      <= '0;
      r_cwr     <= '0;
      r_drop    <= 1'b0;
      r_dropped <= '0;
    end else if (w_drop_start) begin
      r_wr   <= r_cwr;
      r_drop <= !(w_beat && s_axis_tlast);
      if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
    end else if (r_drop) begin
      if (w_beat && s_axis_tlast) r_drop <= 1'b0;
    end else if (w_wr_en) begin
      r_wr <= r_wr + 1'b1;
      if (s_axis_tlast) r_cwr <= r_wr + 1'b1;
    end
  end

  assign w_avail   = r_cwr != r_rd;
  assign w_rd_last = w_rd_word[72];
  assign w_consume = ((r_state == c_st_start) && mac_tx_ack) || (r_state == c_st_stream);

  // Look one word ahead on consumption so STREAM sees a new word every cycle.
  assign w_rd_addr = r_rd[BW-1:0] + BW'(w_consume);

  xge_ibuf #(
    .AW(BW),
    .DW(73)
  ) u_ibuf (
    .clk     (clk),
    .we      (w_wr_en),
    .a       (r_wr[BW-1:0]),
    .d       (w_wr_word),
    .qdpo_clk(clk),
    .dpra    (w_rd_addr),
    .qdpo    (w_rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_rd         <= '0;
      r_start_seen <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd         <= r_rd + {{BW{1'b0}}, w_consume};
      r_start_seen <= (r_state == c_st_start);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_avail) w_state_nxt = c_st_fetch;
      c_st_fetch:  w_state_nxt = c_st_start;
      c_st_start:  if (mac_tx_ack) w_state_nxt = w_rd_last ? c_st_gap : c_st_stream;
      c_st_stream: if (w_rd_last) w_state_nxt = c_st_gap;
      c_st_gap:    w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    mac_tx_start      = 1'b0;
    mac_tx_data       = '0;
    mac_tx_data_valid = '0;
    if ((r_state == c_st_start) || (r_state == c_st_stream)) begin
      mac_tx_start      = (r_state == c_st_start) && !r_start_seen;
      mac_tx_data       = w_rd_word[63:0];
      mac_tx_data_valid = w_rd_word[71:64];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis2mac.sv
// ============================================================================
//  tb_axis2mac
//  Scoreboard bench for axis2mac: default-depth and BW=4 instances.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis2mac;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tvalid;
  logic        tlast;
  logic        mac_ack;
  logic        sel;

  logic        tready_a, start_a, tready_b, start_b;
  logic [63:0] data_a, data_b;
  logic [7:0]  valid_a, valid_b;
  logic [15:0] dropped_a, dropped_b;

  logic        m_tready, m_start;
  logic [63:0] m_data;
  logic [7:0]  m_valid;
  logic [15:0] m_dropped;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   starts = 0;
  int   frames_out = 0;
  int   hold_cnt = 0;
  int   last_hold = 0;
  bit   streaming = 0;
  bit   holding = 0;
  bit   exp_gap = 0;
  int   beats_acc = 0;
  int   low_cnt = 0;
  int   first_low = -1;
  int   ack_delay = 2;

  always #5 clk = ~clk;

  axis2mac u_dut_a (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (tdata),
    .s_axis_tstrb     (tstrb),
    .s_axis_tvalid    (tvalid && !sel),
    .s_axis_tlast     (tlast),
    .s_axis_tready    (tready_a),
    .mac_tx_data      (data_a),
    .mac_tx_data_valid(valid_a),
    .mac_tx_start     (start_a),
    .mac_tx_ack       (mac_ack && !sel),
    .dropped_pkts     (dropped_a)
  );

  axis2mac #(.BW(4)) u_dut_b (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (tdata),
    .s_axis_tstrb     (tstrb),
    .s_axis_tvalid    (tvalid && sel),
    .s_axis_tlast     (tlast),
    .s_axis_tready    (tready_b),
    .mac_tx_data      (data_b),
    .mac_tx_data_valid(valid_b),
    .mac_tx_start     (start_b),
    .mac_tx_ack       (mac_ack && sel),
    .dropped_pkts     (dropped_b)
  );

  assign m_tready  = sel ? tready_b  : tready_a;
  assign m_start   = sel ? start_b   : start_a;
  assign m_data    = sel ? data_b    : data_a;
  assign m_valid   = sel ? valid_b   : valid_a;
  assign m_dropped = sel ? dropped_b : dropped_a;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // MAC model: ack a fixed number of cycles after start, or always when 0.
  initial begin
    mac_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_delay == 0) mac_ack = 1'b1;
      else if (m_start) begin
        mac_ack = 1'b0;
        repeat (ack_delay) @(posedge clk);
        #1 mac_ack = 1'b1;
        @(posedge clk);
        #1 mac_ack = 1'b0;
      end else mac_ack = 1'b0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      streaming = 0;
      holding   = 0;
      exp_gap   = 0;
      hold_cnt  = 0;
    end else begin
      if (exp_gap) begin
        chk("gap_valid", 64'(m_valid), 64'd0);
        exp_gap = 0;
      end
      if (m_valid == 8'h00) begin
        if (streaming) begin
          chk("stream_no_bubble", 64'(m_valid != 8'h00), 64'd1);
          streaming = 0;
        end
        chk("idle_data_zero", m_data, 64'd0);
        chk("idle_no_start", 64'(m_start), 64'd0);
      end else begin
        if (!streaming) begin
          chk("start_pulse", 64'(m_start), 64'(!holding));
          if (exp_q.size() > 0) chk("held_word", m_data, exp_q[0].data);
          if (m_start) starts++;
          holding = 1;
          hold_cnt++;
        end
        if (streaming || mac_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word", 64'(m_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("word_data", m_data, e.data);
            chk("word_valid", 64'(m_valid), 64'(e.strb));
            if (holding) begin
              last_hold = hold_cnt;
              hold_cnt  = 0;
              holding   = 0;
            end
            if (e.last) begin
              streaming = 0;
              exp_gap   = 1;
              frames_out++;
            end else streaming = 1;
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l, input bit keep);
    exp_t e;
    tdata  = d;
    tstrb  = s;
    tlast  = l;
    tvalid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (m_tready) begin
        if (keep) begin
          e.data = d;
          e.strb = s;
          e.last = l;
          exp_q.push_back(e);
        end
        beats_acc++;
        @(posedge clk);
        #1 tvalid = 1'b0;
        return;
      end
      low_cnt++;
      if (first_low < 0) first_low = beats_acc;
      @(posedge clk);
      #1;
    end
    chk("tready_timeout", 64'd0, 64'd1);
    tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] last_strb, input bit keep, input int gap_pct);
    logic [63:0] d;
    for (int b = 0; b < len; b++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      d = {$urandom, $urandom};
      send_beat(d, (b == len - 1) ? last_strb : 8'hFF, b == len - 1, keep);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !streaming && !holding) done = 1;
    end
    chk("drain_done", 64'(done), 64'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    int s0, f0, nb;
    bit hit;
    logic [7:0] ff, ls;
    ff = 8'hFF;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0; sel = 1'b0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_tready", 64'(tready_a), 64'd0);
    chk("rst_valid", 64'(valid_a), 64'd0);
    chk("rst_data", data_a, 64'd0);
    chk("rst_start", 64'(start_a), 64'd0);
    chk("rst_tready_b", 64'(tready_b), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("tready_after_rst", 64'(m_tready), 64'd1);
    chk("dropped_after_rst", 64'(dropped_a), 64'd0);
    chk("dropped_after_rst_b", 64'(dropped_b), 64'd0);

    // 3-beat frame, ack two cycles after start.
    s0 = starts; f0 = frames_out; ack_delay = 2;
    send_frame(3, 8'h0F, 1, 0);
    drain();
    chk("t1_starts", 64'(starts - s0), 64'd1);
    chk("t1_hold", 64'(last_hold), 64'd3);
    chk("t1_frames", 64'(frames_out - f0), 64'd1);

    // Single-word frame.
    s0 = starts; f0 = frames_out; ack_delay = 1;
    send_frame(1, 8'h01, 1, 0);
    drain();
    chk("t2_starts", 64'(starts - s0), 64'd1);
    chk("t2_hold", 64'(last_hold), 64'd2);
    chk("t2_frames", 64'(frames_out - f0), 64'd1);
    chk("t2_idle", 64'(m_valid), 64'd0);

    // BW=4: oversize frame is dropped without stalling the source.
    sel = 1'b1; ack_delay = 2; low_cnt = 0;
    s0 = starts; f0 = frames_out;
    send_frame(20, 8'hFF, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("t3_tready_low", 64'(low_cnt), 64'd0);
    chk("t3_dropped", 64'(m_dropped), 64'd1);
    chk("t3_no_output", 64'(starts - s0), 64'd0);
    send_frame(4, 8'h3F, 1, 0);
    drain();
    chk("t3_frames", 64'(frames_out - f0), 64'd1);
    chk("t3_dropped_after", 64'(m_dropped), 64'd1);

    // BW=4: back-to-back frames, slow ack, across the address wrap.
    ack_delay = 5; beats_acc = 0; first_low = -1; low_cnt = 0; f0 = frames_out;
    send_frame(10, 8'h07, 1, 0);
    send_frame(10, 8'hFF, 1, 0);
    drain();
    chk("t4_full_at", 64'(first_low), 64'd16);
    chk("t4_frames", 64'(frames_out - f0), 64'd2);
    chk("t4_dropped", 64'(m_dropped), 64'd1);

    // Reset during STREAM of the second frame.
    sel = 1'b0; ack_delay = 0; f0 = frames_out; hit = 0;
    send_frame(3, 8'hFF, 1, 0);
    send_frame(12, 8'h1F, 1, 0);
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (frames_out == f0 + 1 && streaming) hit = 1;
    end
    chk("t5_reached_stream", 64'(hit), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_valid", 64'(m_valid), 64'd0);
    chk("t5_rst_data", m_data, 64'd0);
    chk("t5_rst_start", 64'(m_start), 64'd0);
    chk("t5_rst_tready", 64'(m_tready), 64'd0);
    exp_q.delete();
    s0 = starts; f0 = frames_out;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t5_tready_after", 64'(m_tready), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("t5_no_starts", 64'(starts - s0), 64'd0);
    chk("t5_no_frames", 64'(frames_out - f0), 64'd0);

    // 200 frames with random lengths, last-byte counts and source gaps.
    f0 = frames_out;
    for (int f = 0; f < 200; f++) begin
      nb = $urandom_range(8, 1);
      ls = ff >> (8 - nb);
      send_frame($urandom_range(64, 1), ls, 1, 30);
    end
    drain();
    chk("t6_frames", 64'(frames_out - f0), 64'd200);
    chk("t6_dropped", 64'(dropped_a), 64'd0);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
